// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the 5x5 convolution controller.
package conv_pkg;
    localparam int K       = 5;
    localparam int DW      = 12;
    localparam int CW      = 8;
    localparam int NCOEFF  = K * K;
    localparam int COEFF_W = NCOEFF * CW;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;
endpackage

// File: rtl/conv_coeff_regs.sv
// 25-byte coefficient register file; rejects out-of-range or in-frame writes via a sticky error.
module conv_coeff_regs
    import conv_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [4:0]         addr,
    input  logic [CW-1:0]      data,
    input  logic               busy,
    input  logic               clr,
    output logic [COEFF_W-1:0] coeff,
    output logic               err
);
    logic [CW-1:0] coeff_mem_reg [NCOEFF];
    logic          err_reg;
    logic          addr_ok;
    logic          wr_ok;
    logic          wr_bad;

    assign addr_ok = (addr <= 5'(NCOEFF - 1));
    assign wr_ok   = we & addr_ok & ~busy;
    assign wr_bad  = we & (~addr_ok | busy);

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCOEFF; i++) begin
            if (!rst) begin
                coeff_mem_reg[i] <= '0;
            end else if (wr_ok && (addr == 5'(i))) begin
                coeff_mem_reg[i] <= data;
            end
        end
    end

    // An illegal write in the same cycle as a frame start still leaves the flag set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_reg <= 1'b0;
        end else if (wr_bad) begin
            err_reg <= 1'b1;
        end else if (clr) begin
            err_reg <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < NCOEFF; gi++) begin : g_pack
            assign coeff[gi*CW +: CW] = coeff_mem_reg[gi];
        end
    endgenerate

    assign err = err_reg;
endmodule

// File: rtl/conv2d_ctrl.sv
// Frame sequencer for buffer_2d: feeds pixels, tracks valid-window tags, flushes and returns results.
module conv2d_ctrl
    import conv_pkg::*;
#(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int BUF_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic               cfg_we,
    input  logic [4:0]         cfg_addr,
    input  logic [CW-1:0]      cfg_data,
    output logic               cfg_err,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DW-1:0]      s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [DW-1:0]      m_data,
    output logic               buf_rst,
    output logic               buf_en,
    output logic [COEFF_W-1:0] buf_coeff,
    output logic [DW-1:0]      buf_din,
    input  logic [DW-1:0]      buf_dout
);
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int FL_W  = (BUF_LAT > 1) ? $clog2(BUF_LAT) : 1;

    state_t             state_reg;
    state_t             state_next;
    logic [COL_W-1:0]   col_reg;
    logic [ROW_W-1:0]   row_reg;
    logic [FL_W-1:0]    flush_cnt_reg;
    logic [BUF_LAT-1:0] tag_line_reg;
    logic               m_valid_reg;
    logic [DW-1:0]      m_data_reg;

    logic stall;
    logic start_frame;
    logic accept;
    logic tag_in;
    logic last_pixel;
    logic flush_last;
    logic capture;

    // Capture happens on the very edge that shifts a tag out, so no result is ever left pending.
    assign stall       = m_valid_reg & ~m_ready;
    assign start_frame = (state_reg == ST_IDLE) & start;
    assign s_ready     = (state_reg == ST_RUN) & ~stall;
    assign accept      = s_valid & s_ready;
    assign buf_en      = accept | ((state_reg == ST_FLUSH) & ~stall);
    assign buf_din     = (state_reg == ST_RUN) ? s_data : '0;
    assign tag_in      = (state_reg == ST_RUN) &
                         (int'(row_reg) >= K - 1) & (int'(col_reg) >= K - 1);
    assign last_pixel  = accept & (col_reg == COL_W'(IMG_W - 1)) & (row_reg == ROW_W'(IMG_H - 1));
    assign flush_last  = (flush_cnt_reg == FL_W'(BUF_LAT - 1));
    assign capture     = buf_en & tag_line_reg[BUF_LAT-1];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_RUN;
            ST_RUN:   if (last_pixel) state_next = ST_FLUSH;
            ST_FLUSH: if (buf_en && flush_last) state_next = ST_DRAIN;
            ST_DRAIN: if (!m_valid_reg) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            col_reg       <= '0;
            row_reg       <= '0;
            flush_cnt_reg <= '0;
            tag_line_reg  <= '0;
            m_valid_reg   <= 1'b0;
            m_data_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (start_frame) begin
                col_reg       <= '0;
                row_reg       <= '0;
                flush_cnt_reg <= '0;
                tag_line_reg  <= '0;
            end else begin
                if (accept) begin
                    if (col_reg == COL_W'(IMG_W - 1)) begin
                        col_reg <= '0;
                        row_reg <= row_reg + 1'b1;
                    end else begin
                        col_reg <= col_reg + 1'b1;
                    end
                end
                if (buf_en) begin
                    tag_line_reg <= BUF_LAT'({tag_line_reg, tag_in});
                end
                if ((state_reg == ST_FLUSH) && buf_en) begin
                    flush_cnt_reg <= flush_cnt_reg + 1'b1;
                end
            end
            if (capture) begin
                m_valid_reg <= 1'b1;
                m_data_reg  <= buf_dout;
            end else if (m_ready) begin
                m_valid_reg <= 1'b0;
            end
        end
    end

    conv_coeff_regs u_coeff (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_we),
        .addr  (cfg_addr),
        .data  (cfg_data),
        .busy  (busy),
        .clr   (start_frame),
        .coeff (buf_coeff),
        .err   (cfg_err)
    );

    assign busy    = (state_reg != ST_IDLE);
    assign done    = (state_reg == ST_DONE);
    assign buf_rst = ~rst | start_frame;
    assign m_valid = m_valid_reg;
    assign m_data  = m_data_reg;
endmodule

// File: tb/tb_conv2d_ctrl.sv
// Scoreboard bench for conv2d_ctrl with a simple one-stage behavioural buffer model.
module tb_conv2d_ctrl;
    import conv_pkg::*;

    localparam int IMG_W   = 8;
    localparam int IMG_H   = 8;
    localparam int BUF_LAT = 1;
    localparam int NPIX    = IMG_W * IMG_H;
    localparam int NRES    = (IMG_H - K + 1) * (IMG_W - K + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               busy;
    logic               done;
    logic               cfg_we;
    logic [4:0]         cfg_addr;
    logic [CW-1:0]      cfg_data;
    logic               cfg_err;
    logic               s_valid;
    logic               s_ready;
    logic [DW-1:0]      s_data;
    logic               m_valid;
    logic               m_ready;
    logic [DW-1:0]      m_data;
    logic               buf_rst;
    logic               buf_en;
    logic [COEFF_W-1:0] buf_coeff;
    logic [DW-1:0]      buf_din;
    logic [DW-1:0]      buf_dout;

    always #5 clk = ~clk;

    conv2d_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .BUF_LAT(BUF_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .buf_rst(buf_rst), .buf_en(buf_en), .buf_coeff(buf_coeff),
        .buf_din(buf_din), .buf_dout(buf_dout)
    );

    // Buffer stand-in: one enabled cycle of latency, result = input + 100.
    always @(posedge clk) begin
        if (buf_rst) buf_dout <= '0;
        else if (buf_en) buf_dout <= buf_din + DW'(100);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [COEFF_W-1:0] got,
                             input logic [COEFF_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int i);
        return DW'(i * 37 + 5);
    endfunction

    logic [DW-1:0]      sb [$];
    logic [COEFF_W-1:0] coeff_exp;
    bit                 mon_en = 1'b0;
    int                 acc_cnt, res_cnt, done_cnt, cyc, cyc36;
    bit                 first_seen, stall_prev;
    logic [DW-1:0]      stall_data;

    always @(negedge clk) begin
        cyc++;
        if (mon_en && rst) begin
            if (s_valid && s_ready) begin
                if ((acc_cnt / IMG_W >= K - 1) && (acc_cnt % IMG_W >= K - 1))
                    sb.push_back(s_data + DW'(100));
                if (acc_cnt == 36) cyc36 = cyc;
                acc_cnt++;
            end
            if (m_valid && !first_seen) begin
                first_seen = 1'b1;
                check_val("first_latency", cyc - cyc36, 2);
            end
            if (m_valid && m_ready) begin
                res_cnt++;
                $display("result %0d data=%h", res_cnt, m_data);
                check_val("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) check_val("result_data", m_data, sb.pop_front());
            end
            if (m_valid && !m_ready) begin
                check_val("stall_s_ready", s_ready, 0);
                check_val("stall_buf_en", buf_en, 0);
                if (stall_prev) check_val("stall_hold", m_data, stall_data);
                stall_data = m_data;
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [4:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
        if (a < 5'd25) coeff_exp[int'(a)*8 +: 8] = d;
        $display("cfg write addr=%0d data=%h err=%0b", a, d, cfg_err);
    endtask

    task automatic check_reset_outputs(input string ctx);
        check_val({ctx, "_busy"}, busy, 0);
        check_val({ctx, "_done"}, done, 0);
        check_val({ctx, "_cfg_err"}, cfg_err, 0);
        check_val({ctx, "_s_ready"}, s_ready, 0);
        check_val({ctx, "_m_valid"}, m_valid, 0);
        check_val({ctx, "_m_data"}, m_data, 0);
        check_val({ctx, "_buf_en"}, buf_en, 0);
        check_val({ctx, "_buf_din"}, buf_din, 0);
        check_val({ctx, "_buf_coeff"}, buf_coeff, 0);
        check_val({ctx, "_buf_rst"}, buf_rst, 1);
    endtask

    task automatic run_frame(input bit bp, input bit hold_start, input int abort_at,
                             input bit bad_cfg);
        int idx = 0;
        int guard = 0;
        int bp_left = 0;
        bit bp_done = 1'b0;
        bit cfg_done = 1'b0;
        bit acc;
        acc_cnt = 0; res_cnt = 0; done_cnt = 0; cyc36 = 0;
        first_seen = 1'b0; stall_prev = 1'b0;
        sb.delete();
        start = 1'b1;
        @(negedge clk);
        check_val("start_buf_rst", buf_rst, 1);
        tick();
        if (!hold_start) start = 1'b0;
        check_val("start_busy", busy, 1);
        check_val("start_cfg_err_clr", cfg_err, 0);
        s_valid = 1'b1;
        s_data  = pix(0);
        while (idx < NPIX && guard < 5000) begin
            @(negedge clk);
            acc = s_valid && s_ready;
            tick();
            guard++;
            if (acc) begin
                idx++;
                s_data = pix(idx);
            end
            if (idx == NPIX) s_valid = 1'b0;
            if (bad_cfg && idx == 10 && !cfg_done) begin
                cfg_we = 1'b1; cfg_addr = 5'd3; cfg_data = 8'h55; cfg_done = 1'b1;
            end else begin
                cfg_we = 1'b0;
            end
            if (bp && !bp_done && m_valid) begin
                m_ready = 1'b0; bp_left = 5; bp_done = 1'b1;
            end else if (bp_left > 0) begin
                bp_left--;
                if (bp_left == 0) m_ready = 1'b1;
            end
            if (idx == abort_at) begin
                s_valid = 1'b0;
                rst = 1'b0;
                tick();
                check_reset_outputs("abort");
                coeff_exp = '0;
                rst = 1'b1;
                tick();
                $display("frame aborted at pixel %0d", idx);
                return;
            end
        end
        m_ready = 1'b1;
        cfg_we  = 1'b0;
        check_val("pixels_accepted", idx, NPIX);
        guard = 0;
        while (done_cnt == 0 && guard < 500) begin
            tick();
            guard++;
        end
        start = 1'b0;
        repeat (4) tick();
        check_val("done_pulses", done_cnt, 1);
        check_val("result_count", res_cnt, NRES);
        check_val("sb_empty", sb.size(), 0);
        check_val("idle_busy", busy, 0);
        $display("frame end results=%0d done=%0d", res_cnt, done_cnt);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        s_valid = 1'b0; s_data = 12'habc; m_ready = 1'b1; coeff_exp = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();
        mon_en = 1'b1;

        cfg_write(5'd12, 8'h02);
        cfg_write(5'd11, 8'h01);
        cfg_write(5'd13, 8'h01);
        cfg_write(5'd7,  8'hff);
        cfg_write(5'd8,  8'hfe);
        cfg_write(5'd9,  8'hff);
        check_val("coeff_load", buf_coeff, coeff_exp);
        check_val("coeff_no_err", cfg_err, 0);

        cfg_write(5'd25, 8'h77);
        check_val("illegal_addr_coeff", buf_coeff, coeff_exp);
        check_val("illegal_addr_err", cfg_err, 1);

        run_frame(1'b0, 1'b0, -1, 1'b1);
        check_val("run_write_coeff", buf_coeff, coeff_exp);
        check_val("run_write_err", cfg_err, 1);

        run_frame(1'b1, 1'b0, -1, 1'b0);
        run_frame(1'b0, 1'b0, 20, 1'b0);
        check_val("abort_coeff_cleared", buf_coeff, coeff_exp);
        run_frame(1'b0, 1'b0, -1, 1'b0);
        run_frame(1'b0, 1'b1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
